fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Shares the single write port of a `FIFO` instance between `REQUESTER_COUNT` peripheral requesters, such as UART RX, SPI RX and debug, using one-word-per-grant arbitration. The `FIFO` registers `we` and `dataIn` on the rising edge, commits on the falling edge and updates `bufferFull` after the commit. The arbiter therefore sequences writes so that no grant is ever issued against a stale `bufferFull`. It sits directly between the requesters and the `FIFO` write side; the read side is untouched.

## Interface
- `WORD_SIZE`, 8, width of one data word; must match the `FIFO`.
- `REQUESTER_COUNT`, 4, number of requesters, 2..16.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset; assertion clears all state immediately.
- `requestValid`  in  `REQUESTER_COUNT`  bit i: requester i holds a word to write.
- `requestData`  in  `REQUESTER_COUNT*WORD_SIZE`  word of requester i at bits [i*WORD_SIZE +: WORD_SIZE].
- `requestAccept`  out  `REQUESTER_COUNT`  one-cycle one-hot pulse: the word of requester i has been taken.
- `fifoDataIn`  out  `WORD_SIZE`  to `FIFO.dataIn`.
- `fifoWe`  out  1  to `FIFO.we`.
- `fifoBufferFull`  in  1  from `FIFO.bufferFull`.
- `grantIndex`  out  `$clog2(REQUESTER_COUNT)`  index of the last granted requester.
- `busy`  out  1  high while the state is WRITE or SETTLE.

## Operation
- States: IDLE, WRITE, SETTLE. All outputs are registered.
- **Decision edge:** any rising edge where the state is IDLE or SETTLE.
  - If any `requestValid` bit is set and `fifoBufferFull`=0: select a winner, go to WRITE, set `fifoWe`=1, `fifoDataIn`=winner's word, `requestAccept`=one-hot(winner), `grantIndex`=winner.
  - Otherwise go to IDLE with `fifoWe`=0 and `requestAccept`=0.
- **WRITE:** at the next edge, unconditionally go to SETTLE; `fifoWe` and `requestAccept` return to 0. `fifoDataIn` holds its value.
- **SETTLE:** exists because `bufferFull` reflects the write only after the `FIFO`'s falling-edge commit inside this cycle. SETTLE behaves as a decision edge.
- **Requester rules:**
  - `requestValid` and the data must be held stable until `requestAccept`.
  - Dropping `requestValid` before accept withdraws the request; no write occurs.
  - After accept, the requester may present a new word in the next cycle.
- **Selection:** the search starts at `(lastGrant+1) mod REQUESTER_COUNT` and takes the first set `requestValid` bit. `lastGrant` is reset to `REQUESTER_COUNT-1`, so requester 0 is first.
- **Full FIFO:** no grant is issued and requests wait. Data is never lost through the arbiter, so the `FIFO`'s `dataLost` must stay 0.
- **Reset values:**
  - State IDLE, `fifoWe`=0, `requestAccept`=0.
  - `fifoDataIn`=0, `grantIndex`=0, `busy`=0, `lastGrant`=`REQUESTER_COUNT-1`.
- **Reset mid-WRITE:** outputs clear asynchronously. A write the `FIFO` has already sampled still completes unless the `FIFO` is reset too.

## Timing
- `requestValid` set before edge t, state IDLE, not full → `fifoWe` and `requestAccept` high during cycle t..t+1.
- The `FIFO` samples at t+1 and commits at the falling edge in t+1. The next decision is at t+2.
- Latency from valid to accept: 1 edge when the arbiter is idle.
- Maximum throughput: one word per 2 cycles.
- Worst-case wait for requester i with all requesters active: 2×(`REQUESTER_COUNT`-1) cycles.

## Configuration
- `FIFO_WRITE_ARBITER_ROUND_ROBIN_EN` defined: round-robin selection as described above.
- Undefined: fixed priority; the lowest set index always wins, and `lastGrant` is unused (`grantIndex` still reports the winner).

## Structure
- Shared package `fifo_arbiter_pkg`:
  - state encoding: IDLE=2'd0, WRITE=2'd1, SETTLE=2'd2;
  - a `$clog2` helper clamped to a minimum of 1.
- Sub-module `rr_priority_select`:
  - combinational rotate-and-find-first over `REQUESTER_COUNT` bits;
  - inputs: request vector and start index; outputs: winner index and any-valid.
  - Fixed priority is the same sub-module with start index 0.

## Test plan
- Single request: requester 2 valid with data 8'hA5 on an empty FIFO → `fifoWe` for 1 cycle with 8'hA5, `requestAccept`=4'b0100; `FIFO` `dataOut`=8'hA5 two cycles later.
- All 4 requesters held valid, round-robin build → grant order 0,1,2,3,0 on edges 2 cycles apart; no requester starves.
- Same stimulus, macro undefined → requester 0 is granted every 2 cycles; the others receive no accept.
- `FIFO` `BUFFER_SIZE`=4, one requester streaming continuously → exactly 3 words accepted, then `fifoWe` stays 0 while `fifoBufferFull`=1. After one `oe` read, exactly one more accept. `dataLost` stays 0 throughout.
- `rst` pulsed low during WRITE → `fifoWe`, `requestAccept` and `busy` drop to 0 without waiting for a clock edge; the first grant after release goes to requester 0.
- Requester 1 deasserts `requestValid` while requester 0 is being written → requester 1 gets no accept and nothing from it is written.

Source files
------------

// File: rtl/fifo_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2
  } arb_state_e;

  // $clog2 that never returns 0, so a 1-bit index is still legal for tiny counts
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotate-and-find-first: returns the first set request at or after the start index.
module rr_priority_select
  import fifo_arbiter_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [IDX_W-1:0] o_winner_c,
  output logic             o_any_c
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  assign w_rot = N'({i_req, i_req} >> i_start);

  // Descending scan so the lowest rotated position is the one that sticks
  always_comb begin
    w_off   = '0;
    o_any_c = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off   = IDX_W'(k);
        o_any_c = 1'b1;
      end
    end
  end

  assign w_sum      = {1'b0, i_start} + {1'b0, w_off};
  assign o_winner_c = (w_sum >= N_W) ? IDX_W'(w_sum - N_W) : IDX_W'(w_sum);

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port among several requesters, one word per grant with a settle cycle.
// Define FIFO_WRITE_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (lowest index).
module fifo_write_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE       = 8,
  parameter int unsigned REQUESTER_COUNT = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [REQUESTER_COUNT-1:0]                requestValid,
  input  logic [REQUESTER_COUNT*WORD_SIZE-1:0]      requestData,
  output logic [REQUESTER_COUNT-1:0]                requestAccept,
  output logic [WORD_SIZE-1:0]                      fifoDataIn,
  output logic                                      fifoWe,
  input  logic                                      fifoBufferFull,
  output logic [clog2_min1(REQUESTER_COUNT)-1:0]    grantIndex,
  output logic                                      busy
);

  localparam int unsigned IDX_W = clog2_min1(REQUESTER_COUNT);

  arb_state_e       r_state;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_winner;
  logic             w_any;
  logic [WORD_SIZE-1:0] w_word;

`ifdef FIFO_WRITE_ARBITER_ROUND_ROBIN_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQUESTER_COUNT - 1);

  logic [IDX_W-1:0] r_last_grant;

  assign w_start = (r_last_grant == LAST_IDX) ? '0 : r_last_grant + 1'b1;
`else
  assign w_start = '0;
`endif

  rr_priority_select #(
    .N     (REQUESTER_COUNT),
    .IDX_W (IDX_W)
  ) u_select (
    .i_req      (requestValid),
    .i_start    (w_start),
    .o_winner_c (w_winner),
    .o_any_c    (w_any)
  );

  assign w_word = requestData[32'(w_winner) * WORD_SIZE +: WORD_SIZE];

  // Decisions only in IDLE/SETTLE so bufferFull always reflects the previous commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      fifoWe        <= 1'b0;
      requestAccept <= '0;
      fifoDataIn    <= '0;
      grantIndex    <= '0;
      busy          <= 1'b0;
`ifdef FIFO_WRITE_ARBITER_ROUND_ROBIN_EN
      r_last_grant  <= LAST_IDX;
`endif
    end else begin
      case (r_state)
        WRITE: begin
          r_state       <= SETTLE;
          fifoWe        <= 1'b0;
          requestAccept <= '0;
          busy          <= 1'b1;
        end
        default: begin
          if (w_any && !fifoBufferFull) begin
            r_state       <= WRITE;
            fifoWe        <= 1'b1;
            fifoDataIn    <= w_word;
            requestAccept <= REQUESTER_COUNT'(1) << w_winner;
            grantIndex    <= w_winner;
            busy          <= 1'b1;
`ifdef FIFO_WRITE_ARBITER_ROUND_ROBIN_EN
            r_last_grant  <= w_winner;
`endif
          end else begin
            r_state       <= IDLE;
            fifoWe        <= 1'b0;
            requestAccept <= '0;
            busy          <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
